ahb_manager_cmd_gen: RTL and testbench
======================================

AHB_MANAGER_CMD_GEN -- requirements
Module: ahb_manager_cmd_gen

Interface
REQ-001 SHALL have parameter DATA_WDT, default 32, the data width of the manager user interface (32, 64 or 128).
REQ-002 SHALL have one clock and an asynchronous active-high reset, named i_hclk and i_hreset; polarity and synchronicity are fixed.
REQ-003 i_hclk  in  1  clock.
REQ-004 i_hreset  in  1  asynchronous active-high reset.
REQ-005 i_req_valid  in  1  transfer descriptor valid.
REQ-006 o_req_ready  out  1  descriptor accepted when valid and ready are both 1.
REQ-007 i_req_addr  in  32  start byte address.
REQ-008 i_req_len  in  16  total beats.
REQ-009 i_req_size  in  t_hsize  beat size.
REQ-010 i_req_write  in  1  1 = write, 0 = read.
REQ-011 i_wdata_valid  in  1  write-data stream valid.
REQ-012 i_wdata  in  DATA_WDT  write-data stream payload.
REQ-013 o_wdata_ready  out  1  write-data stream ready.
REQ-014 o_done  out  1  one-cycle pulse when a descriptor completes.
REQ-015 o_err  out  1  one-cycle pulse when a descriptor is rejected.
REQ-016 i_stall  in  1  manager UI stall; all o_mgr_* outputs are ignored while 1.
REQ-017 o_mgr_idle, o_mgr_wr, o_mgr_rd, o_mgr_first_xfer  out  1 each  manager UI controls.
REQ-018 o_mgr_addr  out  32  manager UI address; o_mgr_size  out  t_hsize  manager UI size.
REQ-019 o_mgr_min_len  out  16  manager UI minimum burst length; o_mgr_wr_data  out  DATA_WDT  manager UI write data.

Function
REQ-020 SHALL implement states IDLE, BURST and FIN.
- IDLE: o_mgr_idle=1, o_req_ready=1.
- BURST: o_mgr_idle=0, o_req_ready=0.
- FIN: o_mgr_idle=1, o_req_ready=0, o_done=1 for exactly one cycle.
REQ-021 On acceptance in IDLE, SHALL check the descriptor.
- Reject if size exceeds log2(DATA_WDT/8) or if the address is misaligned to the size.
- On reject: pulse o_err next cycle, stay in IDLE, issue no beats.
REQ-022 On acceptance with i_req_len=0 and no error, SHALL go to FIN directly, issuing no beats.
REQ-023 Otherwise SHALL load the address register, the remaining counter (=len) and the size register, then enter BURST.
REQ-024 A beat SHALL be accepted when all of the following hold: state is BURST, i_stall=0, and o_mgr_rd|o_mgr_wr is 1.
- On acceptance: address += (1<<size); remaining -= 1.
REQ-025 While i_stall=1, every o_mgr_* output SHALL hold its value.
REQ-026 Read descriptors SHALL present o_mgr_rd=1 on every BURST cycle (reads are never gapped).
REQ-027 For writes, SHALL drive o_mgr_wr=i_wdata_valid and o_mgr_wr_data=i_wdata.
- o_wdata_ready = BURST & write & ~i_stall.
- When i_wdata_valid=0, o_mgr_wr=0 and o_mgr_idle stays 0 (gap); address and counters hold.
REQ-028 The write-data source SHALL hold valid and data until accepted.
REQ-029 SHALL split a transfer into sub-bursts that never cross a 1KB boundary.
- beats_to_boundary = (1024 - addr[9:0]) >> size.
- o_mgr_min_len = min(remaining, beats_to_boundary), computed at each sub-burst start and held for that sub-burst.
REQ-030 o_mgr_first_xfer SHALL be 1 on the first beat of each sub-burst and 0 on all other beats.
- It remains 1 through stalls and write gaps until that first beat is accepted.
REQ-031 When the last beat is accepted (remaining 1 -> 0), SHALL go to FIN, then to IDLE on the next cycle.
- This guarantees at least one o_mgr_idle=1 cycle between descriptors.
REQ-032 o_mgr_size SHALL hold constant for the whole descriptor.

Reset
REQ-033 While i_hreset=1, the block SHALL be in IDLE, with the following output values:
- o_mgr_idle=1, o_req_ready=1.
- o_mgr_wr, o_mgr_rd, o_mgr_first_xfer, o_done, o_err, o_wdata_ready = 0.
- o_mgr_addr, o_mgr_min_len, o_mgr_wr_data = 0; o_mgr_size = byte.
REQ-034 Reset asserted mid-descriptor SHALL abandon the descriptor immediately, with no o_done pulse.

Verification
REQ-035 Reset: assert i_hreset for 3 cycles mid-burst -> all REQ-033 values, o_mgr_idle=1 from the first reset cycle.
REQ-036 Read: addr 0x100, word, len 4, i_stall=0 -> 4 beats, addresses 0x100/0x104/0x108/0x10C.
- min_len=4; first_xfer on beat 1 only.
- o_done pulses the cycle after beat 4.
REQ-037 1KB split: write, addr 0x3F8, word, len 6 -> sub-burst 1 at 0x3F8 with min_len 2.
- Sub-burst 2 at 0x400 with first_xfer=1 and min_len 4.
- 6 data words consumed in order.
REQ-038 Stall: i_stall=1 for 3 cycles after beat 2 of a 4-beat read -> all o_mgr_* held for 3 cycles; beat 3 then issues at addr+8.
REQ-039 Write gap: i_wdata_valid=0 for 2 cycles mid-burst -> o_mgr_wr=0, o_mgr_idle=0, address held; the burst resumes with no extra first_xfer.
REQ-040 Reject: addr 0x102, word -> o_err pulses once, no beats issued, o_req_ready=1 the next cycle.

Source files
------------

// File: rtl/ahb_manager_cmd_gen.sv
// AHB manager command generator: turns transfer descriptors into manager-UI beats,
// splitting bursts at 1KB boundaries and streaming write data through.
package ahb_manager_cmd_gen_pkg;
    typedef logic [2:0] t_hsize;
    localparam t_hsize HSIZE_BYTE = 3'd0;
endpackage

module ahb_manager_cmd_gen
    import ahb_manager_cmd_gen_pkg::*;
#(
    parameter int DATA_WDT = 32
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [31:0]         i_req_addr,
    input  logic [15:0]         i_req_len,
    input  t_hsize              i_req_size,
    input  logic                i_req_write,
    input  logic                i_wdata_valid,
    input  logic [DATA_WDT-1:0] i_wdata,
    output logic                o_wdata_ready,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_stall,
    output logic                o_mgr_idle,
    output logic                o_mgr_wr,
    output logic                o_mgr_rd,
    output logic                o_mgr_first_xfer,
    output logic [31:0]         o_mgr_addr,
    output t_hsize              o_mgr_size,
    output logic [15:0]         o_mgr_min_len,
    output logic [DATA_WDT-1:0] o_mgr_wr_data
);
    localparam t_hsize MAX_SIZE = t_hsize'($clog2(DATA_WDT / 8));

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_FIN} t_state;

    t_state      state, state_nxt;
    logic [31:0] addr;
    logic [31:0] addr_nxt;
    logic [15:0] remaining;
    logic [15:0] sub_rem;
    logic [15:0] min_len;
    logic [15:0] start_len;
    logic [15:0] next_len;
    t_hsize      size;
    logic        write;
    logic        first;
    logic        err_q;
    logic        req_err;
    logic        burst;
    logic        beat;

    // Beats from offset to the next 1KB boundary, clipped to what is left.
    function automatic logic [15:0] sub_len(input logic [9:0] offs, input t_hsize s,
                                            input logic [15:0] rem);
        logic [15:0] btb;
        btb = (16'd1024 - {6'd0, offs}) >> s;
        return (btb < rem) ? btb : rem;
    endfunction

    assign req_err   = (i_req_size > MAX_SIZE) ||
                       ((i_req_addr & ((32'd1 << i_req_size) - 32'd1)) != '0);
    assign burst     = (state == S_BURST);
    assign beat      = burst && !i_stall && (o_mgr_rd || o_mgr_wr);
    assign addr_nxt  = addr + (32'd1 << size);
    assign start_len = sub_len(i_req_addr[9:0], i_req_size, i_req_len);
    assign next_len  = sub_len(addr_nxt[9:0], size, remaining - 16'd1);

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        o_req_ready = 1'b0;
        o_mgr_idle  = 1'b1;
        o_done      = 1'b0;
        case (state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid && !req_err)
                    state_nxt = (i_req_len == '0) ? S_FIN : S_BURST;
            end
            S_BURST: begin
                o_mgr_idle = 1'b0;
                if (beat && remaining == 16'd1) state_nxt = S_FIN;
            end
            S_FIN: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            addr      <= '0;
            remaining <= '0;
            sub_rem   <= '0;
            min_len   <= '0;
            size      <= HSIZE_BYTE;
            write     <= 1'b0;
            first     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && i_req_valid && req_err;
            if (state == S_IDLE && i_req_valid && !req_err && i_req_len != '0) begin
                addr      <= i_req_addr;
                remaining <= i_req_len;
                size      <= i_req_size;
                write     <= i_req_write;
                min_len   <= start_len;
                sub_rem   <= start_len;
                first     <= 1'b1;
            end else if (beat) begin
                addr      <= addr_nxt;
                remaining <= remaining - 16'd1;
                // Closing a sub-burst with beats still owed opens the next one.
                if (sub_rem == 16'd1 && remaining != 16'd1) begin
                    min_len <= next_len;
                    sub_rem <= next_len;
                    first   <= 1'b1;
                end else begin
                    sub_rem <= sub_rem - 16'd1;
                    first   <= 1'b0;
                end
            end
        end
    end

    assign o_err            = err_q;
    assign o_mgr_rd         = burst && !write;
    assign o_mgr_wr         = burst && write && i_wdata_valid;
    assign o_wdata_ready    = burst && write && !i_stall;
    assign o_mgr_wr_data    = (burst && write) ? i_wdata : '0;
    assign o_mgr_first_xfer = burst && first;
    assign o_mgr_addr       = addr;
    assign o_mgr_size       = size;
    assign o_mgr_min_len    = min_len;
endmodule

// File: tb/tb_ahb_manager_cmd_gen.sv
// Randomized bench for ahb_manager_cmd_gen: expected beats are derived per descriptor
// from address arithmetic and 1KB boundary rules.
module tb_ahb_manager_cmd_gen;
    import ahb_manager_cmd_gen_pkg::*;

    localparam int DW    = 32;
    localparam int MAXSZ = 2;

    logic          i_hclk = 1'b0;
    logic          i_hreset = 1'b1;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [31:0]   i_req_addr = '0;
    logic [15:0]   i_req_len = '0;
    t_hsize        i_req_size = '0;
    logic          i_req_write = 1'b0;
    logic          i_wdata_valid = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic          o_wdata_ready;
    logic          o_done;
    logic          o_err;
    logic          i_stall = 1'b0;
    logic          o_mgr_idle;
    logic          o_mgr_wr;
    logic          o_mgr_rd;
    logic          o_mgr_first_xfer;
    logic [31:0]   o_mgr_addr;
    t_hsize        o_mgr_size;
    logic [15:0]   o_mgr_min_len;
    logic [DW-1:0] o_mgr_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_manager_cmd_gen #(.DATA_WDT(DW)) dut (
        .i_hclk(i_hclk), .i_hreset(i_hreset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_req_write(i_req_write),
        .i_wdata_valid(i_wdata_valid), .i_wdata(i_wdata), .o_wdata_ready(o_wdata_ready),
        .o_done(o_done), .o_err(o_err), .i_stall(i_stall),
        .o_mgr_idle(o_mgr_idle), .o_mgr_wr(o_mgr_wr), .o_mgr_rd(o_mgr_rd),
        .o_mgr_first_xfer(o_mgr_first_xfer), .o_mgr_addr(o_mgr_addr),
        .o_mgr_size(o_mgr_size), .o_mgr_min_len(o_mgr_min_len),
        .o_mgr_wr_data(o_mgr_wr_data)
    );

    always #5 i_hclk = ~i_hclk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_idle"}, o_mgr_idle, 1);
        check_eq({tag, "_ready"}, o_req_ready, 1);
        check_eq({tag, "_wr"}, o_mgr_wr, 0);
        check_eq({tag, "_rd"}, o_mgr_rd, 0);
        check_eq({tag, "_first"}, o_mgr_first_xfer, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_err"}, o_err, 0);
        check_eq({tag, "_wready"}, o_wdata_ready, 0);
        check_eq({tag, "_addr"}, o_mgr_addr, 0);
        check_eq({tag, "_minlen"}, o_mgr_min_len, 0);
        check_eq({tag, "_wrdata"}, o_mgr_wr_data, 0);
        check_eq({tag, "_size"}, o_mgr_size, 0);
    endtask

    // Drives stall and write-data for the coming cycle; the data source holds
    // valid/data until accepted and keeps them still across consecutive stalls.
    task automatic drive_cycle(input int i, input int len, input bit wr,
                               input int stall_pct, input int gap_pct,
                               input int stall_at, input int stall_len,
                               input int gap_at, input int gap_len,
                               input bit acc_prev, inout int stalls, inout int gaps);
        bit prev_stall;
        prev_stall = i_stall;
        if (i >= len) begin
            i_stall = 1'b0;
            i_wdata_valid = 1'b0;
            return;
        end
        if (i == stall_at && stalls < stall_len) begin
            i_stall = 1'b1;
            stalls++;
        end else begin
            i_stall = ($urandom_range(99) < stall_pct);
        end
        if (!wr) begin
            i_wdata_valid = 1'b0;
        end else if (i_wdata_valid && !acc_prev) begin
            // pending word stays put
        end else if (prev_stall && i_stall) begin
            // stall continues: hold the idle source too
        end else if (i == gap_at && gaps < gap_len) begin
            i_wdata_valid = 1'b0;
            gaps++;
        end else begin
            i_wdata_valid = ($urandom_range(99) >= gap_pct);
            if (i_wdata_valid) i_wdata = $urandom;
        end
    endtask

    task automatic do_desc(input logic [31:0] a, input int len, input int sz, input bit wr,
                           input int stall_pct, input int gap_pct,
                           input int stall_at, input int stall_len,
                           input int gap_at, input int gap_len);
        bit err, ef, acc;
        int i, budget, stalls, gaps, ml;
        logic [31:0] ea;
        @(negedge i_hclk);
        i_req_valid = 1'b1;
        i_req_addr  = a;
        i_req_len   = len[15:0];
        i_req_size  = t_hsize'(sz);
        i_req_write = wr;
        #1;
        check_eq("accept_ready", o_req_ready, 1);
        check_eq("accept_idle", o_mgr_idle, 1);
        err = (sz > MAXSZ) || ((a % (32'd1 << sz)) != 0);
        @(negedge i_hclk);
        i_req_valid = 1'b0;
        if (err) begin
            #1;
            check_eq("rej_err", o_err, 1);
            check_eq("rej_ready", o_req_ready, 1);
            check_eq("rej_idle", o_mgr_idle, 1);
            check_eq("rej_rd", o_mgr_rd, 0);
            check_eq("rej_wr", o_mgr_wr, 0);
            @(negedge i_hclk); #1;
            check_eq("rej_err_once", o_err, 0);
            check_eq("rej_no_beat", o_mgr_idle, 1);
            return;
        end
        if (len == 0) begin
            #1;
            check_eq("zero_done", o_done, 1);
            check_eq("zero_idle", o_mgr_idle, 1);
            check_eq("zero_ready", o_req_ready, 0);
            check_eq("zero_rd", o_mgr_rd, 0);
            @(negedge i_hclk); #1;
            check_eq("zero_done_once", o_done, 0);
            check_eq("zero_ready_back", o_req_ready, 1);
            return;
        end
        i = 0; budget = 0; stalls = 0; gaps = 0; ml = 0; acc = 1'b1;
        drive_cycle(i, len, wr, stall_pct, gap_pct, stall_at, stall_len, gap_at, gap_len,
                    acc, stalls, gaps);
        #1;
        while (i < len) begin
            ea = a + (32'(i) << sz);
            ef = (i == 0) || (ea % 1024 == 0);
            if (ef) begin
                ml = (1024 - int'(ea % 1024)) / (1 << sz);
                if (len - i < ml) ml = len - i;
            end
            check_eq("b_idle", o_mgr_idle, 0);
            check_eq("b_ready", o_req_ready, 0);
            check_eq("b_rd", o_mgr_rd, !wr);
            check_eq("b_wr", o_mgr_wr, wr && i_wdata_valid);
            check_eq("b_addr", o_mgr_addr, ea);
            check_eq("b_first", o_mgr_first_xfer, ef);
            check_eq("b_min_len", o_mgr_min_len, ml);
            check_eq("b_size", o_mgr_size, sz);
            check_eq("b_wready", o_wdata_ready, wr && !i_stall);
            check_eq("b_done", o_done, 0);
            if (wr && i_wdata_valid) check_eq("b_wdata", o_mgr_wr_data, i_wdata);
            acc = !i_stall && (!wr || i_wdata_valid);
            if (acc) i++;
            budget++;
            if (budget > 3000) begin
                check_eq("burst_timeout", 0, 1);
                break;
            end
            @(negedge i_hclk);
            drive_cycle(i, len, wr, stall_pct, gap_pct, stall_at, stall_len, gap_at, gap_len,
                        acc, stalls, gaps);
            #1;
        end
        check_eq("fin_done", o_done, 1);
        check_eq("fin_idle", o_mgr_idle, 1);
        check_eq("fin_ready", o_req_ready, 0);
        check_eq("fin_rd", o_mgr_rd, 0);
        check_eq("fin_wr", o_mgr_wr, 0);
        @(negedge i_hclk);
        i_stall = 1'b0;
        i_wdata_valid = 1'b0;
        #1;
        check_eq("post_done", o_done, 0);
        check_eq("post_ready", o_req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int sz, len;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge i_hclk);
        i_hreset = 1'b0;
        #1;
        check_eq("por_release_ready", o_req_ready, 1);

        // directed cases
        do_desc(32'h100, 4, 2, 1'b0, 0, 0, -1, 0, -1, 0);
        do_desc(32'h3F8, 6, 2, 1'b1, 0, 0, -1, 0, -1, 0);
        do_desc(32'h200, 4, 2, 1'b0, 0, 0, 2, 3, -1, 0);
        do_desc(32'h300, 5, 2, 1'b1, 0, 0, -1, 0, 2, 2);
        do_desc(32'h102, 4, 2, 1'b0, 0, 0, -1, 0, -1, 0);
        do_desc(32'h104, 0, 2, 1'b1, 0, 0, -1, 0, -1, 0);
        do_desc(32'h100, 2, 3, 1'b0, 0, 0, -1, 0, -1, 0);
        do_desc(32'h3FF, 3, 0, 1'b1, 0, 0, -1, 0, -1, 0);

        // reset in the middle of a read burst
        @(negedge i_hclk);
        i_req_valid = 1'b1; i_req_addr = 32'h500; i_req_len = 16'd8;
        i_req_size = 3'd2; i_req_write = 1'b0;
        @(negedge i_hclk);
        i_req_valid = 1'b0;
        repeat (2) @(negedge i_hclk);
        #1;
        check_eq("pre_rst_busy", o_mgr_idle, 0);
        @(negedge i_hclk);
        i_hreset = 1'b1;
        #1;
        check_reset_outputs("rst_c1");
        @(negedge i_hclk); #1;
        check_reset_outputs("rst_c2");
        @(negedge i_hclk); #1;
        check_reset_outputs("rst_c3");
        @(negedge i_hclk);
        i_hreset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("rst_no_done", o_done, 0);
            check_eq("rst_idle", o_mgr_idle, 1);
            @(negedge i_hclk);
        end

        // randomized descriptors
        for (int n = 0; n < 60; n++) begin
            sz  = $urandom_range(0, 3);
            a   = 32'($urandom_range(1, 60)) * 32'd1024 - (32'($urandom_range(0, 8)) << sz);
            if ($urandom_range(9) == 0 && sz > 0) a = a | 32'd1;
            len = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 20);
            do_desc(a, len, sz, 1'($urandom_range(1)), $urandom_range(0, 30),
                    $urandom_range(0, 30), -1, 0, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
